// File: rtl/barril_engine.sv
`default_nettype none
// ============================================================================
//  Module   : barril_engine
//  Purpose  : Multi-barrel sprite engine. Holds NUM_BARRILES independent
//             barrel slots, each with its own position and a roll/fall state
//             machine advanced once per frame. Per pixel it resolves the
//             lowest-index active barrel whose sprite pixel is opaque at
//             (hcount, vcount) and emits its 2-bit colour index.
//
//  Ports    : clk            pixel clock
//             rst            synchronous, active-high reset
//             hcount/vcount  current pixel coordinates (10 bit)
//             bounds_draw    visible-area qualifier
//             display_barril global draw enable
//             frame_tick     one-cycle pulse per frame, advances all slots
//             spawn          one-cycle request to launch a barrel
//             barril_draw    registered colour index, 00 = transparent
//             barril_hit_id  registered slot index driving barril_draw
//             active_mask    registered, bit i = slot i not idle
//             spawn_drop     one-cycle pulse, spawn ignored (no free slot)
//
//  Revision : 1.0  initial release
// ============================================================================
module barril_engine #(
    parameter int NUM_BARRILES = 4,
    parameter int SPRITE_SIZE  = 16,
    parameter int SPAWN_H      = 100,
    parameter int SPAWN_V      = 80,
    parameter int H_LEFT       = 40,
    parameter int H_RIGHT      = 584,
    parameter int V_BOTTOM     = 448,
    parameter int SPEED        = 1,
    parameter int FALL_SPEED   = 2,
    parameter int FALL_DIST    = 32,
    localparam int HIT_ID_W    = (NUM_BARRILES > 1) ? $clog2(NUM_BARRILES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [9:0]              hcount,
    input  logic [9:0]              vcount,
    input  logic                    bounds_draw,
    input  logic                    display_barril,
    input  logic                    frame_tick,
    input  logic                    spawn,
    output logic [1:0]              barril_draw,
    output logic [HIT_ID_W-1:0]     barril_hit_id,
    output logic [NUM_BARRILES-1:0] active_mask,
    output logic                    spawn_drop
);

    // Sprite offsets are taken from the low bits of the pixel offset; the
    // sprite edge is a power of two.
    localparam int OFF_W = $clog2(SPRITE_SIZE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROLL = 2'd1;
    localparam logic [1:0] S_FALL = 2'd2;

    localparam logic [9:0] c_spawn_h    = 10'(SPAWN_H);
    localparam logic [9:0] c_spawn_v    = 10'(SPAWN_V);
    localparam logic [9:0] c_h_left     = 10'(H_LEFT);
    localparam logic [9:0] c_h_left_lim = 10'(H_LEFT + SPEED);
    localparam logic [9:0] c_h_right    = 10'(H_RIGHT);
    localparam logic [9:0] c_v_bottom   = 10'(V_BOTTOM);
    localparam logic [9:0] c_speed      = 10'(SPEED);
    localparam logic [9:0] c_fall_speed = 10'(FALL_SPEED);
    localparam logic [9:0] c_fall_dist  = 10'(FALL_DIST);
    localparam logic [9:0] c_size       = 10'(SPRITE_SIZE);

    // barrilMem: a rounded barrel body. Mirroring the offsets folds the
    // four corners onto one; corners closer than 3 pixels (Manhattan) to the
    // sprite edge are transparent. Every fourth row is a hoop, the two
    // outermost columns are the rim shading, the rest is the wooden body.
    function automatic logic [1:0] barril_mem(input logic [OFF_W-1:0] x,
                                               input logic [OFF_W-1:0] y);
        logic [OFF_W-1:0] mx;
        logic [OFF_W-1:0] my;
        logic [OFF_W-1:0] rim;
        logic [1:0]       col;
        mx  = x[OFF_W-1] ? ~x : x;
        my  = y[OFF_W-1] ? ~y : y;
        rim = mx + my;
        if (rim < OFF_W'(3))       col = 2'b00;
        else if (y[1:0] == 2'b00)  col = 2'b11;
        else if (mx < OFF_W'(2))   col = 2'b10;
        else                       col = 2'b01;
        return col;
    endfunction

    // Slot registers
    logic [1:0]              r_state    [NUM_BARRILES];
    logic [9:0]              r_h        [NUM_BARRILES];
    logic [9:0]              r_v        [NUM_BARRILES];
    logic [9:0]              r_fall_cnt [NUM_BARRILES];
    logic [NUM_BARRILES-1:0] r_dir;

    // Slot next-state
    logic [1:0]              w_state_nx [NUM_BARRILES];
    logic [9:0]              w_h_nx     [NUM_BARRILES];
    logic [9:0]              w_v_nx     [NUM_BARRILES];
    logic [9:0]              w_fc_nx    [NUM_BARRILES];
    logic [NUM_BARRILES-1:0] w_dir_nx;
    logic [NUM_BARRILES-1:0] w_active_nx;

    logic [9:0]              w_h_inc;
    logic [9:0]              w_v_new;
    logic [9:0]              w_fc_new;

    logic                    w_free_found;
    logic [HIT_ID_W-1:0]     w_free_idx;

    // Pixel path
    logic [9:0]              w_dx;
    logic [9:0]              w_dy;
    logic [1:0]              w_col;
    logic [1:0]              w_pix;
    logic [HIT_ID_W-1:0]     w_pix_id;

    // Output registers
    logic [1:0]              r_draw;
    logic [HIT_ID_W-1:0]     r_hit_id;
    logic [NUM_BARRILES-1:0] r_active;
    logic                    r_spawn_drop;

    // Lowest-index idle slot; scanning downward lets the lowest index win.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_BARRILES - 1; i >= 0; i--) begin
            if (r_state[i] == S_IDLE) begin
                w_free_found = 1'b1;
                w_free_idx   = HIT_ID_W'(i);
            end
        end
    end

    // Per-slot next state. A slot chosen by spawn is loaded and not moved on
    // a coincident frame_tick; the bottom despawn check runs after the move.
    always_comb begin
        w_h_inc  = '0;
        w_v_new  = '0;
        w_fc_new = '0;
        w_dir_nx = r_dir;
        for (int i = 0; i < NUM_BARRILES; i++) begin
            w_state_nx[i] = r_state[i];
            w_h_nx[i]     = r_h[i];
            w_v_nx[i]     = r_v[i];
            w_fc_nx[i]    = r_fall_cnt[i];
            w_h_inc       = r_h[i] + c_speed;
            w_v_new       = r_v[i] + c_fall_speed;
            w_fc_new      = r_fall_cnt[i] + c_fall_speed;
            if (spawn && w_free_found && (w_free_idx == HIT_ID_W'(i))) begin
                w_state_nx[i] = S_ROLL;
                w_h_nx[i]     = c_spawn_h;
                w_v_nx[i]     = c_spawn_v;
                w_fc_nx[i]    = '0;
                w_dir_nx[i]   = 1'b0;
            end else if (frame_tick) begin
                case (r_state[i])
                    S_ROLL: begin
                        if (!r_dir[i]) begin
                            if (w_h_inc >= c_h_right) begin
                                w_h_nx[i]     = c_h_right;
                                w_fc_nx[i]    = '0;
                                w_state_nx[i] = S_FALL;
                            end else begin
                                w_h_nx[i] = w_h_inc;
                            end
                        end else begin
                            if (r_h[i] <= c_h_left_lim) begin
                                w_h_nx[i]     = c_h_left;
                                w_fc_nx[i]    = '0;
                                w_state_nx[i] = S_FALL;
                            end else begin
                                w_h_nx[i] = r_h[i] - c_speed;
                            end
                        end
                    end
                    S_FALL: begin
                        w_v_nx[i]  = w_v_new;
                        w_fc_nx[i] = w_fc_new;
                        if (w_fc_new >= c_fall_dist) begin
                            w_dir_nx[i]   = ~r_dir[i];
                            w_state_nx[i] = S_ROLL;
                        end
                    end
                    default: ;
                endcase
                if (w_v_nx[i] >= c_v_bottom) begin
                    w_state_nx[i] = S_IDLE;
                end
            end
        end
    end

    always_comb begin
        w_active_nx = '0;
        for (int i = 0; i < NUM_BARRILES; i++) begin
            w_active_nx[i] = (w_state_nx[i] != S_IDLE);
        end
    end

    // Pixel resolution. Offsets are unsigned differences, so after the
    // hcount >= h check "dx < size" is the exclusive right edge without any
    // overflow concern. Transparent pixels never win, exposing the barrel
    // behind; the downward scan gives the lowest index final say.
    always_comb begin
        w_pix    = '0;
        w_pix_id = '0;
        w_dx     = '0;
        w_dy     = '0;
        w_col    = '0;
        for (int i = NUM_BARRILES - 1; i >= 0; i--) begin
            w_dx  = hcount - r_h[i];
            w_dy  = vcount - r_v[i];
            w_col = barril_mem(w_dx[OFF_W-1:0], w_dy[OFF_W-1:0]);
            if (bounds_draw && display_barril && (r_state[i] != S_IDLE) &&
                (hcount >= r_h[i]) && (vcount >= r_v[i]) &&
                (w_dx < c_size) && (w_dy < c_size) && (w_col != 2'b00)) begin
                w_pix    = w_col;
                w_pix_id = HIT_ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BARRILES; i++) begin
                r_state[i]    <= S_IDLE;
                r_h[i]        <= c_spawn_h;
                r_v[i]        <= c_spawn_v;
                r_fall_cnt[i] <= '0;
            end
            r_dir        <= '0;
            r_draw       <= '0;
            r_hit_id     <= '0;
            r_active     <= '0;
            r_spawn_drop <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BARRILES; i++) begin
                r_state[i]    <= w_state_nx[i];
                r_h[i]        <= w_h_nx[i];
                r_v[i]        <= w_v_nx[i];
                r_fall_cnt[i] <= w_fc_nx[i];
            end
            r_dir        <= w_dir_nx;
            r_draw       <= w_pix;
            r_hit_id     <= w_pix_id;
            r_active     <= w_active_nx;
            r_spawn_drop <= spawn && !w_free_found;
        end
    end

    assign barril_draw   = r_draw;
    assign barril_hit_id = r_hit_id;
    assign active_mask   = r_active;
    assign spawn_drop    = r_spawn_drop;

endmodule
`default_nettype wire

// File: tb/tb_barril_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_barril_engine
//  Purpose  : Scoreboard bench for barril_engine. Each driven cycle pushes
//             the expected registered outputs, computed from a behavioural
//             model of the barrel slots, into a queue; a monitor pops and
//             compares after every clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_barril_engine;

    localparam int NB = 4;
    localparam int SZ = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    hcount, vcount;
    logic          bounds_draw, display_barril, frame_tick, spawn;
    logic [1:0]    barril_draw;
    logic [1:0]    barril_hit_id;
    logic [NB-1:0] active_mask;
    logic          spawn_drop;

    always #5 clk = ~clk;

    barril_engine #(
        .NUM_BARRILES(NB), .SPRITE_SIZE(SZ), .SPAWN_H(100), .SPAWN_V(80),
        .H_LEFT(40), .H_RIGHT(584), .V_BOTTOM(448), .SPEED(1),
        .FALL_SPEED(2), .FALL_DIST(32)
    ) dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .bounds_draw(bounds_draw), .display_barril(display_barril),
        .frame_tick(frame_tick), .spawn(spawn),
        .barril_draw(barril_draw), .barril_hit_id(barril_hit_id),
        .active_mask(active_mask), .spawn_drop(spawn_drop)
    );

    typedef struct packed {
        logic [1:0]    draw;
        logic [1:0]    id;
        logic [NB-1:0] mask;
        logic          drop;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic chk = 1'b0;

    // ---------------- behavioural model ----------------
    // slot kind: 0 idle, 1 rolling, 2 falling
    int m_st[NB], m_h[NB], m_v[NB], m_dir[NB], m_fc[NB];

    function automatic int sprite(input int x, input int y);
        int mx, my;
        mx = (x < SZ/2) ? x : SZ - 1 - x;
        my = (y < SZ/2) ? y : SZ - 1 - y;
        if (mx + my < 3) return 0;
        if (y % 4 == 0)  return 3;
        if (mx < 2)      return 2;
        return 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_st[i] = 0; m_h[i] = 100; m_v[i] = 80; m_dir[i] = 0; m_fc[i] = 0;
        end
    endtask

    task automatic model_move(input int i);
        if (m_st[i] == 1) begin
            if (m_dir[i] == 0) begin
                if (m_h[i] + 1 >= 584) begin m_h[i] = 584; m_fc[i] = 0; m_st[i] = 2; end
                else m_h[i] = m_h[i] + 1;
            end else begin
                if (m_h[i] <= 40 + 1) begin m_h[i] = 40; m_fc[i] = 0; m_st[i] = 2; end
                else m_h[i] = m_h[i] - 1;
            end
        end else if (m_st[i] == 2) begin
            m_v[i]  = m_v[i] + 2;
            m_fc[i] = m_fc[i] + 2;
            if (m_fc[i] >= 32) begin m_dir[i] = 1 - m_dir[i]; m_st[i] = 1; end
        end
        if (m_st[i] != 0 && m_v[i] >= 448) m_st[i] = 0;
    endtask

    task automatic model_pixel(input int hc, input int vc, input bit bd, input bit dp,
                               output int col, output int id);
        int c;
        col = 0; id = 0;
        if (bd && dp) begin
            for (int i = 0; i < NB; i++) begin
                if (col == 0 && m_st[i] != 0 &&
                    hc >= m_h[i] && hc < m_h[i] + SZ && vc >= m_v[i] && vc < m_v[i] + SZ) begin
                    c = sprite(hc - m_h[i], vc - m_v[i]);
                    if (c != 0) begin col = c; id = i; end
                end
            end
        end
    endtask

    task automatic model_step(input bit sp, input bit tk, output bit drop);
        int free;
        free = -1;
        drop = 1'b0;
        for (int i = 0; i < NB; i++) if (m_st[i] == 0 && free < 0) free = i;
        for (int i = 0; i < NB; i++) if (tk && !(sp && i == free)) model_move(i);
        if (sp) begin
            if (free >= 0) begin
                m_st[free] = 1; m_h[free] = 100; m_v[free] = 80; m_dir[free] = 0; m_fc[free] = 0;
            end else drop = 1'b1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input int hc, input int vc, input bit bd, input bit dp,
                       input bit sp, input bit tk, input bit r);
        exp_t e;
        int   col, id;
        bit   drop;
        @(posedge clk);
        #1;
        hcount = 10'(hc); vcount = 10'(vc);
        bounds_draw = bd; display_barril = dp;
        spawn = sp; frame_tick = tk; rst = r;
        chk = 1'b1;
        e = '0;
        if (r) begin
            model_reset();
        end else begin
            model_pixel(hc, vc, bd, dp, col, id);
            model_step(sp, tk, drop);
            e.draw = 2'(col);
            e.id   = 2'(id);
            e.drop = drop;
            for (int i = 0; i < NB; i++) e.mask[i] = (m_st[i] != 0);
        end
        sb.push_back(e);
    endtask

    task automatic pix(input int hc, input int vc);
        cyc(hc, vc, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick_probe(input int k);
        int hc, vc;
        hc = m_h[k] + int'($urandom_range(0, SZ + 3)) - 2;
        vc = m_v[k] + int'($urandom_range(0, SZ + 3)) - 2;
        cyc(hc, vc, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic raster(input int h0, input int h1, input int v0, input int v1);
        for (int v = v0; v <= v1; v++)
            for (int h = h0; h <= h1; h++) pix(h, v);
    endtask

    // ---------------- monitor ----------------
    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        logic p;
        forever begin
            @(posedge clk);
            p = chk;
            #3;
            if (p) begin
                if (sb.size() == 0) begin
                    cmp("scoreboard_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    cmp("barril_draw", int'(barril_draw), int'(e.draw));
                    cmp("barril_hit_id", int'(barril_hit_id), int'(e.id));
                    cmp("active_mask", int'(active_mask), int'(e.mask));
                    cmp("spawn_drop", int'(spawn_drop), int'(e.drop));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        rst = 1'b1; hcount = '0; vcount = '0; bounds_draw = 1'b0;
        display_barril = 1'b0; frame_tick = 1'b0; spawn = 1'b0;
        model_reset();

        // reset state
        cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // single spawn and raster around the sprite
        cyc(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        raster(96, 119, 76, 99);

        // roll to the right edge, fall one ledge, turn back
        for (int t = 0; t < 484; t++) tick_probe(0);
        raster(580, 603, 78, 99);
        for (int t = 0; t < 16; t++) tick_probe(0);
        tick_probe(0);
        raster(578, 601, 108, 131);

        // keep going until falling at v=446, then despawn and reuse
        guard = 0;
        while (!(m_st[0] == 2 && m_v[0] == 446) && guard < 20000) begin
            tick_probe(0);
            guard++;
        end
        cyc(m_h[0] + 8, m_v[0] + 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        raster(98, 117, 78, 97);

        // fill every slot, fifth spawn is dropped
        cyc(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int s = 0; s < 5; s++) cyc(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        pix(108, 88);
        // qualifiers off over an active barrel
        cyc(108, 88, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(108, 88, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // reset in the middle of a line
        for (int h = 95; h <= 120; h++)
            cyc(h, 88, 1'b1, 1'b1, (h == 105), 1'b0, (h == 105));

        // staggered slots: slot 0 and 1 transparent where slot 2 is opaque
        cyc(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        pix(103, 80);
        pix(106, 88);
        raster(96, 122, 78, 97);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int k, hc, vc;
            bit sp, tk, bd, dp, r;
            k  = int'($urandom_range(0, NB - 1));
            sp = ($urandom_range(0, 39) == 0);
            tk = ($urandom_range(0, 2) == 0);
            bd = ($urandom_range(0, 7) != 0);
            dp = ($urandom_range(0, 7) != 0);
            r  = ($urandom_range(0, 999) == 0);
            if (m_st[k] != 0) begin
                hc = m_h[k] + int'($urandom_range(0, SZ + 3)) - 2;
                vc = m_v[k] + int'($urandom_range(0, SZ + 3)) - 2;
            end else begin
                hc = int'($urandom_range(0, 639));
                vc = int'($urandom_range(0, 479));
            end
            cyc(hc, vc, bd, dp, sp, tk, r);
        end

        @(posedge clk);
        #1;
        chk = 1'b0;
        rst = 1'b0; spawn = 1'b0; frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        cmp("scoreboard_leftover", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
